// File: rtl/spartan_fifo_sync.sv
// rtl/spartan_fifo_sync.sv - single-clock first-word-fall-through FIFO for the VAL/RDY bus
// Distributed-RAM storage with registered flags derived from a separate entry counter.
module spartan_fifo_sync #(
    parameter int DATA_WIDTH   = 1,
    parameter int ADDRW        = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DIN_VAL,
    output logic                  DIN_RDY,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DOUT_VAL,
    input  logic                  DOUT_RDY,
    output logic [ADDRW:0]        LEVEL,
    output logic                  ALMOST_FULL
);

    localparam int DEPTH = 1 << ADDRW;
    localparam logic [ADDRW:0] DEPTH_C = (ADDRW + 1)'(DEPTH);
    localparam logic [ADDRW:0] AFULL_C = (ADDRW + 1)'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDRW-1:0] head_q, head_d;
    logic [ADDRW-1:0] tail_q, tail_d;
    logic [ADDRW:0]   count_q, count_d;
    logic             din_rdy_q;
    logic             dout_val_q;
    logic             afull_q;

    logic push;
    logic pop;

    // Flush swallows any handshake in the same cycle.
    assign push = DIN_VAL & din_rdy_q & ~FLUSH;
    assign pop  = DOUT_VAL & DOUT_RDY & ~FLUSH;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (FLUSH) begin
            tail_d  = head_q;
            count_d = '0;
        end else begin
            if (push) begin
                head_d = head_q + 1'b1;
            end
            if (pop) begin
                tail_d = tail_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            din_rdy_q  <= 1'b1;
            dout_val_q <= 1'b0;
            afull_q    <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            din_rdy_q  <= (count_d != DEPTH_C);
            dout_val_q <= (count_d != '0);
            afull_q    <= (count_d >= AFULL_C);
        end
    end

    // Storage is deliberately left out of reset so it maps onto distributed RAM.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[head_q] <= DIN;
        end
    end

    assign DIN_RDY     = din_rdy_q;
    assign DOUT_VAL    = dout_val_q;
    assign DOUT        = mem_q[tail_q];
    assign LEVEL       = count_q;
    assign ALMOST_FULL = afull_q;

endmodule

// File: tb/tb_spartan_fifo_sync.sv
// tb/tb_spartan_fifo_sync.sv - self-checking bench for spartan_fifo_sync
// Directed vector table, a wrap-around sequence and randomized traffic against a queue model.
module tb_spartan_fifo_sync;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic          CLK;
    logic          RST;
    logic          FLUSH;
    logic [DW-1:0] DIN;
    logic          DIN_VAL;
    logic          DIN_RDY;
    logic [DW-1:0] DOUT;
    logic          DOUT_VAL;
    logic          DOUT_RDY;
    logic [AW:0]   LEVEL;
    logic          ALMOST_FULL;

    spartan_fifo_sync #(
        .DATA_WIDTH  (DW),
        .ADDRW       (AW),
        .AFULL_THRESH(AF)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FLUSH      (FLUSH),
        .DIN        (DIN),
        .DIN_VAL    (DIN_VAL),
        .DIN_RDY    (DIN_RDY),
        .DOUT       (DOUT),
        .DOUT_VAL   (DOUT_VAL),
        .DOUT_RDY   (DOUT_RDY),
        .LEVEL      (LEVEL),
        .ALMOST_FULL(ALMOST_FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q [$];

    typedef struct {
        logic          rst;
        logic          flush;
        logic [DW-1:0] din;
        logic          din_val;
        logic          dout_rdy;
        int            exp_level;
        logic          exp_val;
        logic [DW-1:0] exp_dout;
        logic          exp_rdy;
        logic          exp_af;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most DEPTH words; ready/valid reflect the occupancy before the edge.
    task automatic model_step(input logic rst, input logic flush, input logic [DW-1:0] din,
                              input logic val, input logic rdy);
        bit can_push;
        bit can_pop;
        can_push = model_q.size() < DEPTH;
        can_pop  = model_q.size() > 0;
        if (rst || flush) begin
            model_q.delete();
        end else begin
            if (rdy && can_pop) void'(model_q.pop_front());
            if (val && can_push) model_q.push_back(din);
        end
    endtask

    task automatic cycle(input logic rst, input logic flush, input logic [DW-1:0] din,
                         input logic val, input logic rdy);
        RST      = rst;
        FLUSH    = flush;
        DIN      = din;
        DIN_VAL  = val;
        DOUT_RDY = rdy;
        @(posedge CLK);
        model_step(rst, flush, din, val, rdy);
        #1;
    endtask

    task automatic chk_model(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".level"}, 32'(LEVEL), 32'(n));
        chk({tag, ".val"}, 32'(DOUT_VAL), 32'(n != 0));
        chk({tag, ".rdy"}, 32'(DIN_RDY), 32'(n != DEPTH));
        chk({tag, ".af"}, 32'(ALMOST_FULL), 32'(n >= AF));
        if (n != 0) chk({tag, ".dout"}, 32'(DOUT), 32'(model_q[0]));
    endtask

    task automatic addv(input logic rst, input logic flush, input logic [DW-1:0] din,
                        input logic val, input logic rdy, input int lvl, input logic ev,
                        input logic [DW-1:0] ed, input logic er, input logic ea);
        vec_t v;
        v.rst = rst; v.flush = flush; v.din = din; v.din_val = val; v.dout_rdy = rdy;
        v.exp_level = lvl; v.exp_val = ev; v.exp_dout = ed; v.exp_rdy = er; v.exp_af = ea;
        vecs.push_back(v);
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; DIN = '0; DIN_VAL = 1'b0; DOUT_RDY = 1'b0;

        //   rst flush din    val rdy  lvl val dout   rdy af
        addv(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 0);
        addv(0, 0, 8'hA1, 1, 0,  1, 1, 8'hA1, 1, 0);
        addv(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 0);
        addv(0, 0, 8'h01, 1, 0,  1, 1, 8'h01, 1, 0);
        addv(0, 0, 8'h02, 1, 0,  2, 1, 8'h01, 1, 0);
        addv(0, 0, 8'h03, 1, 0,  3, 1, 8'h01, 1, 1);
        addv(0, 0, 8'h04, 1, 0,  4, 1, 8'h01, 0, 1);
        addv(0, 0, 8'h05, 1, 0,  4, 1, 8'h01, 0, 1);
        addv(0, 0, 8'h06, 1, 1,  3, 1, 8'h02, 1, 1);
        addv(0, 0, 8'h06, 1, 0,  4, 1, 8'h02, 0, 1);
        addv(0, 0, 8'h00, 0, 1,  3, 1, 8'h03, 1, 1);
        addv(0, 0, 8'h00, 0, 1,  2, 1, 8'h04, 1, 0);
        addv(0, 0, 8'h00, 0, 1,  1, 1, 8'h06, 1, 0);
        addv(0, 0, 8'h00, 0, 1,  0, 0, 8'h00, 1, 0);
        addv(0, 0, 8'h00, 0, 1,  0, 0, 8'h00, 1, 0);
        addv(0, 0, 8'h11, 1, 0,  1, 1, 8'h11, 1, 0);
        addv(0, 0, 8'h22, 1, 0,  2, 1, 8'h11, 1, 0);
        addv(0, 0, 8'h33, 1, 0,  3, 1, 8'h11, 1, 1);
        addv(0, 1, 8'hEE, 1, 1,  0, 0, 8'h00, 1, 0);
        addv(0, 0, 8'h55, 1, 0,  1, 1, 8'h55, 1, 0);
        addv(0, 0, 8'h00, 0, 1,  0, 0, 8'h00, 1, 0);
        addv(0, 0, 8'h77, 1, 0,  1, 1, 8'h77, 1, 0);
        addv(0, 0, 8'h88, 1, 0,  2, 1, 8'h77, 1, 0);
        addv(1, 0, 8'h99, 1, 1,  0, 0, 8'h00, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].flush, vecs[i].din, vecs[i].din_val, vecs[i].dout_rdy);
            chk($sformatf("vec%0d.level", i), 32'(LEVEL), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d.val", i), 32'(DOUT_VAL), 32'(vecs[i].exp_val));
            chk($sformatf("vec%0d.rdy", i), 32'(DIN_RDY), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d.af", i), 32'(ALMOST_FULL), 32'(vecs[i].exp_af));
            if (vecs[i].exp_val) chk($sformatf("vec%0d.dout", i), 32'(DOUT), 32'(vecs[i].exp_dout));
        end

        // Streaming through a one-deep backlog: 20 words wrap the pointers five times.
        cycle(0, 0, 8'hF0, 1, 0);
        chk("wrap.prefill", 32'(DOUT), 32'hF0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 8'(i), 1, 1);
            chk($sformatf("wrap%0d.level", i), 32'(LEVEL), 32'd1);
            chk($sformatf("wrap%0d.dout", i), 32'(DOUT), 32'(i));
            chk($sformatf("wrap%0d.rdy", i), 32'(DIN_RDY), 32'd1);
        end
        cycle(0, 0, 8'h00, 0, 1);
        chk_model("wrap.drain");

        for (int i = 0; i < 1000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0), 8'($urandom),
                  ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spartan_fifo_sync.md
Name: spartan_fifo_sync

Overview:
- Single-clock, first-word-fall-through FIFO for the Spartan VAL/RDY bus. It is the same-domain counterpart of the bus async FIFO.
- Sits between a bus producer and consumer that share one clock. It absorbs back-pressure bursts.
- Reports occupancy so upstream arbiters can throttle before the FIFO fills.

Parameters:
- DATA_WIDTH, 1, payload width in bits.
- ADDRW, 4, log2 of storage depth; DEPTH = 2**ADDRW entries.
- AFULL_THRESH, 12, LEVEL at or above which ALMOST_FULL is asserted. Legal range 1..DEPTH.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- FLUSH  input  1  synchronous discard of all stored entries.
- DIN  input  DATA_WIDTH  write payload.
- DIN_VAL  input  1  producer has valid DIN.
- DIN_RDY  output  1  FIFO can accept DIN this cycle.
- DOUT  output  DATA_WIDTH  head-of-queue payload.
- DOUT_VAL  output  1  DOUT holds a valid entry.
- DOUT_RDY  input  1  consumer accepts DOUT this cycle.
- LEVEL  output  ADDRW+1  current entry count, 0..DEPTH.
- ALMOST_FULL  output  1  LEVEL >= AFULL_THRESH.

Behaviour:
- Interface: one clock domain (CLK); RST is synchronous and active-high.
- Reset (RST high at a rising edge):
  - head_ptr, tail_ptr and count clear to 0.
  - DIN_RDY=1, DOUT_VAL=0, LEVEL=0, ALMOST_FULL=0.
  - DOUT is don't-care while DOUT_VAL=0.
  - Storage contents are not cleared.
  - RST has priority over FLUSH, push and pop. Reset mid-burst drops all entries with no partial state.
- Pointers:
  - head_ptr and tail_ptr are ADDRW bits and wrap modulo DEPTH naturally.
  - count is a separate ADDRW+1-bit register; full and empty are derived from count, not from pointer compare.
- push = DIN_VAL & DIN_RDY.
  - Writes DIN to mem[head_ptr].
  - Increments head_ptr.
- pop = DOUT_VAL & DOUT_RDY.
  - Increments tail_ptr.
- count next-state:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push & pop, or on neither.
- DIN_RDY = (count != DEPTH), registered.
  - When full, a simultaneous pop does NOT make DIN_RDY high in the same cycle; no combinational RDY path from DOUT_RDY to DIN_RDY.
  - DIN_RDY returns high in the cycle after the pop.
- DOUT_VAL = (count != 0), registered; DOUT = mem[tail_ptr] (asynchronous read of distributed RAM).
  - Empty with push: no pass-through. DOUT_VAL rises in the cycle after the push, so write-to-output latency is 1 cycle.
- Throughput: sustained 1 push and 1 pop per cycle when 0 < count < DEPTH.
- Handshake rules:
  - DOUT and DOUT_VAL hold stable while DOUT_VAL=1 and DOUT_RDY=0.
  - A producer may drop DIN_VAL at any time; no transfer occurs without DIN_RDY.
- Flush (FLUSH high at a rising edge):
  - Sets tail_ptr <= head_ptr and count <= 0.
  - Any push or pop in that same cycle is ignored.
  - Next cycle: DOUT_VAL=0, DIN_RDY=1, LEVEL=0.
- LEVEL = count.
- ALMOST_FULL registered, computed from next-state count; it tracks LEVEL in the same cycle.
- Wrap-around: pointer rollover from DEPTH-1 to 0 must not disturb ordering. Data must remain strictly FIFO across any number of wraps.
- Illegal/ignored conditions:
  - DIN_VAL with DIN_RDY=0 is ignored.
  - DOUT_RDY with DOUT_VAL=0 is ignored.
  - Neither may change count.

Test Plan:
- ADDRW=2, AFULL_THRESH=3. Reset, then push 0xA1 one cycle -> next cycle DOUT_VAL=1, DOUT=0xA1, LEVEL=1, DIN_RDY=1.
- ADDRW=2, AFULL_THRESH=3. Push 0x01..0x04 with DOUT_RDY=0:
  - LEVEL steps 1,2,3,4.
  - ALMOST_FULL rises with LEVEL=3.
  - After 4th push DIN_RDY=0; a 5th DIN_VAL (0x05) is dropped.
  - Drain yields exactly 0x01,0x02,0x03,0x04, then DOUT_VAL=0.
- ADDRW=2, AFULL_THRESH=3. Full FIFO with simultaneous DIN_VAL=1 and DOUT_RDY=1:
  - Pop 0x01 only; no write that cycle; LEVEL=3.
  - Next cycle DIN_RDY=1, and the write is accepted.
- ADDRW=2, AFULL_THRESH=3. Continuous push and pop of 0x00..0x13 (20 words) after one prefill word:
  - LEVEL stays 1 throughout.
  - Output order is exact across 5 pointer wraps.
  - DIN_RDY never drops.
- ADDRW=2, AFULL_THRESH=3. Fill 3 entries, assert FLUSH together with DIN_VAL=1 (0xEE) and DOUT_RDY=1:
  - Next cycle LEVEL=0, DOUT_VAL=0, DIN_RDY=1.
  - 0xEE is not stored.
  - A subsequent push of 0x55 appears as DOUT=0x55.
- ADDRW=2, AFULL_THRESH=3. Fill 2 entries, assert RST with DIN_VAL=1 and DOUT_RDY=1:
  - Next cycle LEVEL=0, DOUT_VAL=0, DIN_RDY=1, ALMOST_FULL=0.
  - Random push/pop for 1000 cycles then matches a scoreboard model.
